riscv_muldiv: RTL and testbench
===============================

RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width; legal values are even numbers ≥ 8.
REQ-002 Parameter: TAG_W, default 5, width of the destination-register tag carried with each operation.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  operation request; sampled only while ready=1.
REQ-006 Port: op  input  3  function code using RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: rs1_data, rs2_data  input  DATA_W  operands; rs1 is the multiplicand/dividend, rs2 is the multiplier/divisor.
REQ-008 Port: rd_in  input  TAG_W  destination tag captured with start.
REQ-009 Port: flush  input  1  synchronous abort of any in-flight operation.
REQ-010 Port: ready  output  1  high only in IDLE.
REQ-011 Port: busy  output  1  high in MUL or DIV; used as the pipeline stall request.
REQ-012 Port: valid  output  1  one-cycle result strobe.
REQ-013 Port: result  output  DATA_W  operation result; meaningful only while valid=1.
REQ-014 Port: rd_out  output  TAG_W  tag captured at start; meaningful only while valid=1.

Function
REQ-015 States: IDLE, MUL, DIV, DONE, encoded in 2 bits.
REQ-016 IDLE with start=1 latches op, operands and rd_in.
  - op[2]=0: next state MUL.
  - op[2]=1: next state DIV, unless a special case per REQ-021 or REQ-022 applies.
REQ-017 Signed operands are converted to magnitudes at start, and the result sign is fixed up when entering DONE.
  - MULHSU treats only rs1 as signed.
  - The quotient sign is the XOR of the operand signs.
  - The remainder sign follows the dividend.
REQ-018 MUL state: one radix-2 shift-add step per cycle into a 2*DATA_W accumulator.
  - The iteration counter ($clog2(DATA_W)+1 bits) loads DATA_W and decrements.
  - Transition to DONE when the counter reaches 0 after DATA_W steps.
REQ-019 DIV state: one restoring shift-subtract step per cycle, DATA_W steps, then DONE.
REQ-020 Result selection:
  - MUL returns the low DATA_W bits of the product; MULH, MULHSU and MULHU return the high DATA_W bits.
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
REQ-021 Divisor zero: skip the iteration states and go directly to DONE.
  - Quotient = all ones.
  - Remainder = rs1_data unmodified.
  - Applies to both signed and unsigned ops.
REQ-022 Signed overflow (DIV/REM with rs1 = most-negative value and rs2 = all ones): go directly to DONE with quotient = most-negative value and remainder = 0.
REQ-023 DONE asserts valid=1 for exactly one cycle with result and rd_out stable, then returns to IDLE.
  - valid never asserts in any other state.
REQ-024 Latency from the start-sampling edge:
  - Iterative ops: valid is high in the cycle after edge N+DATA_W+1, i.e. 33 cycles later for DATA_W=32.
  - Special cases: valid is high in the cycle after edge N+1.
REQ-025 start while ready=0 is ignored, with no queuing; the requester holds start until it observes ready=1.
REQ-026 Back-to-back operation: the earliest next start is sampled in the IDLE cycle following DONE, giving throughput of one op per DATA_W+2 cycles.
REQ-027 flush=1 in MUL, DIV or DONE forces IDLE on the next edge with valid=0 in that cycle and no result delivered.
  - flush in IDLE has no effect.
  - flush and start asserted together in IDLE: flush has priority and start is ignored.
REQ-028 Operand inputs may change freely after the start edge; only latched copies are used.

Reset
REQ-029 While reset=1, asynchronously:
  - state = IDLE, counter = 0, accumulators = 0.
  - ready=1, busy=0, valid=0, result=0, rd_out=0.
REQ-030 Reset asserted mid-operation discards the operation, and no valid follows reset release.
REQ-031 The first start is honoured on the first rising edge after reset deasserts.

Verification
REQ-032 MUL 7 × 0xFFFFFFFD (−3), rd_in=5 → result 0xFFFFFFEB, rd_out=5, valid 33 cycles after start, busy high for 32 cycles.
REQ-033 rs1=rs2=0xFFFFFFFF: MULHU → 0xFFFFFFFE; MULH → 0x00000000; MULHSU → 0xFFFFFFFF; MUL → 0x00000001.
REQ-034 DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
REQ-035 DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, with valid one cycle after start and busy never high; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0 with the same timing.
REQ-036 Abort and reset cases:
  - flush 10 cycles into a DIV → no valid, ready=1 next cycle, and a following MUL 3×4 returns 12 with correct latency.
  - reset pulse mid-MUL → all outputs 0 immediately and no valid after release.
REQ-037 start held high during an operation → ignored; the second op starts only in the IDLE cycle after DONE, and both results are correct and in order.

Source files
------------

// File: rtl/riscv_muldiv_if.sv
`default_nettype none
// riscv_muldiv_if -- request/response bundle between the issuing pipeline and the mul/div unit.
// Revision 1.0
interface riscv_muldiv_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [TAG_W-1:0]  rd_in;
  logic              flush;
  logic              ready;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] result;
  logic [TAG_W-1:0]  rd_out;

  modport master (
    output start, op, rs1_data, rs2_data, rd_in, flush,
    input  ready, busy, valid, result, rd_out
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_in, flush,
    output ready, busy, valid, result, rd_out
  );
endinterface
`default_nettype wire

// File: rtl/riscv_muldiv.sv
`default_nettype none
// riscv_muldiv -- iterative RV32M multiply (radix-2 shift-add) / divide (restoring) unit.
// Revision 1.0
module riscv_muldiv #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  wire logic      clk,
  input  wire logic      reset,
  riscv_muldiv_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opnd;
  logic [2:0]          op_q;
  logic                neg_main;
  logic                neg_rem;
  logic                ready;
  logic                busy;
  logic                valid;
  logic [DATA_W-1:0]   result;
  logic [TAG_W-1:0]    rd_out;

  logic                rs1_neg;
  logic                rs2_neg;
  logic [DATA_W-1:0]   rs1_mag;
  logic [DATA_W-1:0]   rs2_mag;
  logic                div_zero;
  logic                div_ovf;

  always_comb begin
    rs1_neg  = !(bus.op == 3'b011 || (bus.op[2] && bus.op[0])) && bus.rs1_data[DATA_W-1];
    rs2_neg  = (bus.op[2] ? !bus.op[0] : !bus.op[1]) && bus.rs2_data[DATA_W-1];
    rs1_mag  = rs1_neg ? -bus.rs1_data : bus.rs1_data;
    rs2_mag  = rs2_neg ? -bus.rs2_data : bus.rs2_data;
    div_zero = bus.op[2] && (bus.rs2_data == '0);
    div_ovf  = bus.op[2] && !bus.op[0] && (bus.rs1_data == MOST_NEG) && (bus.rs2_data == '1);
  end

  // acc holds {product_hi, multiplier/product_lo} for MUL and {remainder, dividend/quotient} for DIV.
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] acc_next;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   result_sel;

  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
    div_shift = acc[2*DATA_W-1:DATA_W-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (state == MUL)
      acc_next = {mul_sum, acc[DATA_W-1:1]};
    else if (!div_diff[DATA_W])
      acc_next = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    else
      acc_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    prod_fix = neg_main ? -acc_next : acc_next;
    quo_fix  = neg_main ? -acc_next[DATA_W-1:0] : acc_next[DATA_W-1:0];
    rem_fix  = neg_rem ? -acc_next[2*DATA_W-1:DATA_W] : acc_next[2*DATA_W-1:DATA_W];
    if (op_q[2])
      result_sel = op_q[1] ? rem_fix : quo_fix;
    else
      result_sel = (op_q[1:0] == 2'b00) ? prod_fix[DATA_W-1:0] : prod_fix[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      valid    <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q     <= bus.op;
            rd_out   <= bus.rd_in;
            ready    <= 1'b0;
            neg_main <= rs1_neg ^ rs2_neg;
            neg_rem  <= rs1_neg;
            if (div_zero || div_ovf) begin
              state <= DONE;
              valid <= 1'b1;
              if (div_zero)
                result <= bus.op[1] ? bus.rs1_data : '1;
              else
                result <= bus.op[1] ? '0 : MOST_NEG;
            end else begin
              state <= bus.op[2] ? DIV : MUL;
              busy  <= 1'b1;
              count <= CNT_W'(DATA_W);
              opnd  <= bus.op[2] ? rs2_mag : rs1_mag;
              acc   <= {{DATA_W{1'b0}}, (bus.op[2] ? rs1_mag : rs2_mag)};
            end
          end
        end
        MUL, DIV: begin
          if (bus.flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            acc   <= acc_next;
            count <= count - 1'b1;
            if (count == CNT_W'(1)) begin
              state  <= DONE;
              busy   <= 1'b0;
              valid  <= 1'b1;
              result <= result_sel;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          valid <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing on the DONE cycle withholds the result strobe.
  assign bus.ready  = ready;
  assign bus.busy   = busy;
  assign bus.valid  = valid && !bus.flush;
  assign bus.result = result;
  assign bus.rd_out = rd_out;
endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv.sv
`default_nettype none
// tb_riscv_muldiv -- vector table, abort/reset/back-to-back sequences and random ops against an arithmetic model.
// Revision 1.0
module tb_riscv_muldiv;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  riscv_muldiv_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();
  riscv_muldiv #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    r  = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin p = 64'(sa / ((b == 0) ? 64'sd1 : sb)); r = (b == 0) ? 32'hFFFF_FFFF : p[31:0]; end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin p = 64'(sa % ((b == 0) ? 64'sd1 : sb)); r = (b == 0) ? a : p[31:0]; end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return DATA_W + 1;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res, output logic [4:0] rtag,
                        output int lat, output int bcnt);
    int guard;
    guard = 0;
    while (!bus.ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = tag;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'($urandom); bus.rs1_data = $urandom; bus.rs2_data = $urandom;
    bus.rd_in = 5'($urandom);
    lat = 0; bcnt = 0; res = 'x; rtag = 'x;
    for (int i = 1; i <= 100; i++) begin
      if (bus.busy) bcnt++;
      if (bus.valid) begin
        lat = i; res = bus.result; rtag = bus.rd_out;
        break;
      end
      @(negedge clk);
    end
    chk("valid_seen", 32'(lat != 0), 1);
    if (lat != 0) begin
      @(negedge clk);
      chk("valid_one_cycle", 32'(bus.valid), 0);
      chk("ready_after_done", 32'(bus.ready), 1);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] res, r1, r2, a, b;
    logic [4:0]  rtag, g1, g2, tag;
    logic [2:0]  op;
    int          lat, bcnt, t1, t2, seen;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0001, 33};
    vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33};
    vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33};
    vecs[7]  = '{3'd5, 32'd100,        32'd7,         5'd8,  32'd14,        33};
    vecs[8]  = '{3'd7, 32'd100,        32'd7,         5'd9,  32'd2,         33};
    vecs[9]  = '{3'd5, 32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, 1};
    vecs[10] = '{3'd7, 32'd5,          32'd0,         5'd11, 32'd5,         1};
    vecs[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1};
    vecs[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1};
    vecs[13] = '{3'd4, 32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 1};
    vecs[14] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd15, 32'hFFFF_FFF9, 1};
    vecs[15] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 33};

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_result", bus.result, 0);
    chk("rst_rd_out", 32'(bus.rd_out), 0);
    reset = 1'b0;

    // First start is presented in the same cycle reset drops.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, res, rtag, lat, bcnt);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_rd_out", i), 32'(rtag), 32'(vecs[i].tag));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, (vecs[i].lat == 1) ? 0 : 32);
    end

    // Flush ten cycles into a divide.
    bus.start = 1'b1; bus.op = 3'd4; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3; bus.rd_in = 5'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("div_busy_before_flush", 32'(bus.busy), 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_ready", 32'(bus.ready), 1);
    chk("flush_busy", 32'(bus.busy), 0);
    seen = 0;
    repeat (40) begin
      if (bus.valid) seen = 1;
      @(negedge clk);
    end
    chk("flush_no_valid", seen, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd17, res, rtag, lat, bcnt);
    chk("post_flush_mul", res, 12);
    chk("post_flush_lat", lat, 33);

    // flush together with start in IDLE: start is dropped.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.rs1_data = 32'd2; bus.rs2_data = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_ready", 32'(bus.ready), 1);
    chk("flush_start_busy", 32'(bus.busy), 0);

    // flush on the DONE cycle suppresses the strobe.
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1_data = 32'd5; bus.rs2_data = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !bus.valid; i++) @(negedge clk);
    chk("done_reached", 32'(bus.valid), 1);
    bus.flush = 1'b1;
    #1 chk("flush_done_valid", 32'(bus.valid), 0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_done_ready", 32'(bus.ready), 1);

    // Reset pulse in the middle of a multiply.
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1_data = 32'd123; bus.rs2_data = 32'd456; bus.rd_in = 5'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mul_busy_before_reset", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 1);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_valid", 32'(bus.valid), 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_rd_out", 32'(bus.rd_out), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) seen = 1;
    end
    chk("rst_no_valid", seen, 0);

    // start held high across an operation: second op begins in the IDLE after DONE.
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1_data = 32'd11; bus.rs2_data = 32'd13; bus.rd_in = 5'd3;
    t1 = 0; r1 = '0; g1 = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.valid) begin t1 = i; r1 = bus.result; g1 = bus.rd_out; break; end
    end
    bus.op = 3'd5; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd9; bus.rd_in = 5'd4;
    t2 = 0; r2 = '0; g2 = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 2) bus.start = 1'b0;
      if (bus.valid) begin t2 = i; r2 = bus.result; g2 = bus.rd_out; break; end
    end
    bus.start = 1'b0;
    chk("held_first_lat", t1, 33);
    chk("held_first_res", r1, 143);
    chk("held_first_tag", 32'(g1), 3);
    chk("held_gap", t2, DATA_W + 2);
    chk("held_second_res", r2, 111);
    chk("held_second_tag", 32'(g2), 4);
    @(negedge clk);

    // Random operations with operand biasing toward the corner cases.
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom); a = $urandom; b = $urandom; tag = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: begin a = 32'h8000_0000; b = '1; end
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op(op, a, b, tag, res, rtag, lat, bcnt);
      chk($sformatf("rand%0d_op%0d_result", k, op), res, model(op, a, b));
      chk($sformatf("rand%0d_rd_out", k), 32'(rtag), 32'(tag));
      chk($sformatf("rand%0d_latency", k), lat, exp_lat(op, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
